// File: rtl/aes_pkg.sv
// Shared types, constants and byte-shuffling helpers for the iterative AES-128 core.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    MIX  = 2'd2,
    DONE = 2'd3
  } aes_state_t;

  localparam logic [3:0] NR = 4'd10;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Byte k = 4*col + row sits at [127-8k -: 8]; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_core_hs_if.sv
// Start/busy/done handshake bundle for aes_core_hs; AES_CORE_CBC_EN adds iv and chain_clr.
interface aes_core_hs_if;
  logic         start;
  logic [127:0] key;
  logic [127:0] plaintext;
`ifdef AES_CORE_CBC_EN
  logic [127:0] iv;
  logic         chain_clr;
`endif
  logic         busy;
  logic         done;
  logic [127:0] cyphertext;

  modport master (
    output start, key, plaintext,
`ifdef AES_CORE_CBC_EN
    output iv, chain_clr,
`endif
    input  busy, done, cyphertext
  );

  modport slave (
    input  start, key, plaintext,
`ifdef AES_CORE_CBC_EN
    input  iv, chain_clr,
`endif
    output busy, done, cyphertext
  );
endinterface

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step; sub_rot is SubWord(RotWord(w3)) supplied by the core's S-boxes.
module aes_key_step (
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon,
  input  logic [31:0]  sub_rot,
  output logic [127:0] key_out
);
  logic [31:0] w0_s, w1_s, w2_s, w3_s;

  assign w0_s = key_in[127:96] ^ sub_rot ^ {rcon, 24'h000000};
  assign w1_s = key_in[95:64] ^ w0_s;
  assign w2_s = key_in[63:32] ^ w1_s;
  assign w3_s = key_in[31:0]  ^ w2_s;
  assign key_out = {w0_s, w1_s, w2_s, w3_s};
endmodule

// File: rtl/mixcolumns.sv
// MixColumns on one 32-bit column, byte [31:24] is row 0.
module mixcolumns
  import aes_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] y
);
  logic [7:0] a0_s, a1_s, a2_s, a3_s;

  assign a0_s = col[31:24];
  assign a1_s = col[23:16];
  assign a2_s = col[15:8];
  assign a3_s = col[7:0];

  assign y = {xtime(a0_s) ^ xtime(a1_s) ^ a1_s ^ a2_s ^ a3_s,
              a0_s ^ xtime(a1_s) ^ xtime(a2_s) ^ a2_s ^ a3_s,
              a0_s ^ a1_s ^ xtime(a2_s) ^ xtime(a3_s) ^ a3_s,
              xtime(a0_s) ^ a0_s ^ a1_s ^ a2_s ^ xtime(a3_s)};
endmodule

// File: rtl/sbox.sv
// Combinational (LUT) AES S-box.
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = SBOX[a];
endmodule

// File: rtl/sbox_sync.sv
// Synchronous (EBR-style) AES S-box: lookup registered when en is high.
module sbox_sync
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Registered table read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y <= 8'h00;
    end else if (en) begin
      y <= SBOX[a];
    end
  end
endmodule

// File: rtl/aes_core_hs.sv
// Iterative AES-128 encryption core with start/busy/done handshake and on-the-fly key expansion.
// Optional CBC chaining is built when AES_CORE_CBC_EN is defined.
module aes_core_hs
  import aes_pkg::*;
#(
  parameter int SBOX_SYNC  = 1,
  parameter int DONE_PULSE = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  aes_core_hs_if.slave  bus
);
  localparam logic SYNC  = (SBOX_SYNC != 0);
  localparam logic PULSE = (DONE_PULSE != 0);

  aes_state_t   fsm_r, fsm_nx_s;
  logic [127:0] blk_r, key_r, ct_r;
  logic [3:0]   rnd_r;
  logic         busy_r, done_r;
  logic         load_s, sub_en_s, mix_en_s, fin_s;
  logic [127:0] sub_s, sr_s, mc_s, key_nx_s, blk_nx_s, init_s;
  logic [31:0]  rot_s, ksub_s;
  logic [7:0]   rcon_s;

  assign rot_s = rot_word(key_r[31:0]);

  generate
    if (SYNC) begin : g_sbox_sync
      for (genvar i = 0; i < 16; i++) begin : g_st
        sbox_sync u_sb (.clk(clk), .reset_n(reset_n), .en(sub_en_s),
                        .a(blk_r[8*i +: 8]), .y(sub_s[8*i +: 8]));
      end
      for (genvar j = 0; j < 4; j++) begin : g_ky
        sbox_sync u_sb (.clk(clk), .reset_n(reset_n), .en(sub_en_s),
                        .a(rot_s[8*j +: 8]), .y(ksub_s[8*j +: 8]));
      end
    end else begin : g_sbox_comb
      for (genvar i = 0; i < 16; i++) begin : g_st
        sbox u_sb (.a(blk_r[8*i +: 8]), .y(sub_s[8*i +: 8]));
      end
      for (genvar j = 0; j < 4; j++) begin : g_ky
        sbox u_sb (.a(rot_s[8*j +: 8]), .y(ksub_s[8*j +: 8]));
      end
    end
  endgenerate

  assign sr_s = shift_rows(sub_s);

  for (genvar c = 0; c < 4; c++) begin : g_mc
    mixcolumns u_mc (.col(sr_s[32*c +: 32]), .y(mc_s[32*c +: 32]));
  end

  // Round constant lookup; outside 1..NR the value is unused.
  always_comb begin
    rcon_s = 8'h00;
    if ((rnd_r >= 4'd1) && (rnd_r <= NR)) begin
      rcon_s = RCON[rnd_r];
    end else begin
      rcon_s = 8'h00;
    end
  end

  aes_key_step u_key_step (
    .key_in  (key_r),
    .rcon    (rcon_s),
    .sub_rot (ksub_s),
    .key_out (key_nx_s)
  );

  assign blk_nx_s = ((rnd_r == NR) ? sr_s : mc_s) ^ key_nx_s;

`ifdef AES_CORE_CBC_EN
  logic [127:0] chain_r;
  assign init_s = bus.plaintext ^ (bus.chain_clr ? bus.iv : chain_r) ^ bus.key;

  // Chain register follows each completed ciphertext.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_r <= 128'h0;
    end else if (fin_s) begin
      chain_r <= blk_r;
    end
  end
`else
  assign init_s = bus.plaintext ^ bus.key;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_r <= IDLE;
    end else begin
      fsm_r <= fsm_nx_s;
    end
  end

  // Next-state logic; SUB is bypassed when S-boxes are combinational.
  always_comb begin
    fsm_nx_s = fsm_r;
    case (fsm_r)
      IDLE: begin
        if (bus.start) fsm_nx_s = SYNC ? SUB : MIX;
        else           fsm_nx_s = IDLE;
      end
      SUB:  fsm_nx_s = MIX;
      MIX: begin
        if (rnd_r < NR) fsm_nx_s = SYNC ? SUB : MIX;
        else            fsm_nx_s = DONE;
      end
      DONE: fsm_nx_s = IDLE;
      default: fsm_nx_s = IDLE;
    endcase
  end

  // Per-state datapath strobes.
  always_comb begin
    load_s   = 1'b0;
    sub_en_s = 1'b0;
    mix_en_s = 1'b0;
    fin_s    = 1'b0;
    case (fsm_r)
      IDLE:    load_s   = bus.start;
      SUB:     sub_en_s = 1'b1;
      MIX:     mix_en_s = 1'b1;
      DONE:    fin_s    = 1'b1;
      default: load_s   = 1'b0;
    endcase
  end

  // Round datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_r  <= 128'h0;
      key_r  <= 128'h0;
      ct_r   <= 128'h0;
      rnd_r  <= 4'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (load_s) begin
      blk_r  <= init_s;
      key_r  <= bus.key;
      rnd_r  <= 4'd1;
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (mix_en_s) begin
      blk_r <= blk_nx_s;
      key_r <= key_nx_s;
      if (rnd_r < NR) rnd_r <= rnd_r + 4'd1;
    end else if (fin_s) begin
      ct_r   <= blk_r;
      busy_r <= 1'b0;
      done_r <= 1'b1;
    end else if (PULSE && done_r) begin
      done_r <= 1'b0;
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.cyphertext = ct_r;
endmodule

// File: tb/tb_aes_core_hs.sv
// Bench for aes_core_hs: two instances (EBR S-boxes/held done, LUT S-boxes/pulsed done)
// checked against known vectors and a byte-array AES-128 reference model.
module tb_aes_core_hs;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start_v [2];
  logic [127:0] key_v [2];
  logic [127:0] pt_v [2];
  logic [127:0] iv_v [2];
  logic         clr_v [2];
  logic         busy_v [2];
  logic         done_v [2];
  logic [127:0] ct_v [2];
  logic [127:0] chain_m [2];
  logic [127:0] last_ct [2];
  int           lat_exp [2] = '{21, 11};
  logic [7:0]   sb_m [256];
  int           n_checks = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  aes_core_hs_if bus_a ();
  aes_core_hs_if bus_b ();

  assign bus_a.start = start_v[0];
  assign bus_a.key = key_v[0];
  assign bus_a.plaintext = pt_v[0];
  assign bus_b.start = start_v[1];
  assign bus_b.key = key_v[1];
  assign bus_b.plaintext = pt_v[1];
  assign busy_v[0] = bus_a.busy;
  assign done_v[0] = bus_a.done;
  assign ct_v[0] = bus_a.cyphertext;
  assign busy_v[1] = bus_b.busy;
  assign done_v[1] = bus_b.done;
  assign ct_v[1] = bus_b.cyphertext;
`ifdef AES_CORE_CBC_EN
  assign bus_a.iv = iv_v[0];
  assign bus_a.chain_clr = clr_v[0];
  assign bus_b.iv = iv_v[1];
  assign bus_b.chain_clr = clr_v[1];
`endif

  aes_core_hs #(.SBOX_SYNC(1), .DONE_PULSE(0)) dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
  aes_core_hs #(.SBOX_SYNC(0), .DONE_PULSE(1)) dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, aa, bb;
    acc = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // S-box derived from GF(2^8) inversion plus the affine map, independent of any table.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, xb;
      xb = x[7:0];
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(xb, y[7:0]) == 8'h01) inv = y[7:0];
      end
      sb_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb_m[tmp[23:16]], sb_m[tmp[15:8]], sb_m[tmp[7:0]], sb_m[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int j = 0; j < 16; j++) s[j] = p[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[4*c+row] = sb_m[s[4*((c+row)%4)+row]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*r + j/4][31-8*(j%4) -: 8];
    end
    o = 128'h0;
    for (int j = 0; j < 16; j++) o[127-8*j -: 8] = s[j];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Caller is #1 after an edge with the DUT idle; start is accepted on the very next edge.
  task automatic run_block(input int d, input logic [127:0] k, input logic [127:0] p,
                           input logic clr, input logic [127:0] ivv,
                           input logic [127:0] exp, input string tag, input int mid_cyc);
    int   n;
    logic got_done, busy_ok;
    key_v[d] = k; pt_v[d] = p; clr_v[d] = clr; iv_v[d] = ivv; start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0; key_v[d] = rand128(); pt_v[d] = rand128();
    check_val({tag, "_busy_on_accept"}, 128'(busy_v[d]), 128'(1));
    check_val({tag, "_done_clr_on_accept"}, 128'(done_v[d]), 128'(0));
    check_val({tag, "_ct_hold_on_accept"}, ct_v[d], last_ct[d]);
    n = 0; got_done = 1'b0; busy_ok = 1'b1;
    while (!got_done && n < 40) begin
      if (n + 1 == mid_cyc) begin
        start_v[d] = 1'b1; key_v[d] = rand128(); pt_v[d] = rand128();
      end
      @(posedge clk); n++; #1;
      start_v[d] = 1'b0;
      if (done_v[d]) got_done = 1'b1;
      else if (!busy_v[d]) busy_ok = 1'b0;
    end
    check_val({tag, "_latency"}, 128'(n), 128'(lat_exp[d]));
    check_val({tag, "_busy_during_run"}, 128'(busy_ok), 128'(1));
    check_val({tag, "_busy_off_at_done"}, 128'(busy_v[d]), 128'(0));
    check_val({tag, "_ct"}, ct_v[d], exp);
    last_ct[d] = exp;
    chain_m[d] = exp;
  endtask

  function automatic logic [127:0] model_exp(input int d, input logic [127:0] k, input logic [127:0] p,
                                             input logic clr, input logic [127:0] ivv);
`ifdef AES_CORE_CBC_EN
    return aes_ref(k, p ^ (clr ? ivv : chain_m[d]));
`else
    return aes_ref(k, p);
`endif
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         bad_pulse, bad_stable, clr;
    logic [127:0] k, p, ivv;
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0; key_v[d] = 128'h0; pt_v[d] = 128'h0; iv_v[d] = 128'h0; clr_v[d] = 1'b1;
      chain_m[d] = 128'h0; last_ct[d] = 128'h0;
    end
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_busy_a", 128'(busy_v[0]), 128'(0));
    check_val("reset_done_a", 128'(done_v[0]), 128'(0));
    check_val("reset_ct_a", ct_v[0], 128'h0);
    check_val("reset_ct_b", ct_v[1], 128'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Known-answer, then held done, then back-to-back restarts on the EBR instance.
    run_block(0, K1, P1, 1'b1, 128'h0, C1, "c1_a", -1);
    @(posedge clk); #1;
    check_val("done_held_a", 128'(done_v[0]), 128'(1));
    run_block(0, KB, PB, 1'b1, 128'h0, CB, "appb_a", -1);
    run_block(0, K1, P1, 1'b1, 128'h0, C1, "b2b_a", -1);
    run_block(0, K1, P1, 1'b1, 128'h0, C1, "midstart_a", 5);

    // Reset dropped mid-run must clear outputs without waiting for a clock edge.
    key_v[0] = KB; pt_v[0] = PB; clr_v[0] = 1'b1; iv_v[0] = 128'h0; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check_val("busy_before_reset_a", 128'(busy_v[0]), 128'(1));
    #2 reset_n = 1'b0;
    #1;
    check_val("async_reset_busy_a", 128'(busy_v[0]), 128'(0));
    check_val("async_reset_done_a", 128'(done_v[0]), 128'(0));
    check_val("async_reset_ct_a", ct_v[0], 128'h0);
    for (int d = 0; d < 2; d++) begin
      chain_m[d] = 128'h0; last_ct[d] = 128'h0;
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_block(0, K1, P1, 1'b1, 128'h0, C1, "after_reset_a", -1);

    // LUT instance with pulsed done.
    run_block(1, K1, P1, 1'b1, 128'h0, C1, "c1_b", -1);
    run_block(1, KB, PB, 1'b1, 128'h0, CB, "appb_b", -1);
    bad_pulse = 1'b0; bad_stable = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (done_v[1]) bad_pulse = 1'b1;
      if (ct_v[1] !== last_ct[1]) bad_stable = 1'b1;
    end
    check_val("done_one_cycle_b", 128'(bad_pulse), 128'(0));
    check_val("ct_stable_50_b", 128'(bad_stable), 128'(0));

`ifdef AES_CORE_CBC_EN
    run_block(0, K1, P1, 1'b1, 128'h0, C1, "cbc_first_a", -1);
    run_block(0, K1, P1, 1'b0, 128'h0, aes_ref(K1, P1 ^ C1), "cbc_chain_a", -1);
    ivv = rand128();
    run_block(1, KB, PB, 1'b1, ivv, aes_ref(KB, PB ^ ivv), "cbc_iv_b", -1);
`endif

    // Randomised blocks against the reference model.
    for (int i = 0; i < 6; i++) begin
      for (int d = 0; d < 2; d++) begin
        k = rand128(); p = rand128(); ivv = rand128();
        clr = 1'($urandom_range(0, 1));
        run_block(d, k, p, clr, ivv, model_exp(d, k, p, clr, ivv), $sformatf("rand%0d_%0d", i, d), -1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_core_hs.md
Name: aes_core_hs

Overview:
- Iterative AES-128 encryption core (FIPS-197, Nk=4, Nb=4, Nr=10).
- Successor to the lab AES core:
  - true asynchronous active-low reset;
  - start/busy/done handshake;
  - parameterised S-box implementation (LUT or EBR), which sets the cycles per round;
  - optional CBC chaining.
- Sits between aes_spi and the top level, replacing the fixed-schedule core.
- Round keys are expanded on the fly, one per round.

Parameters:
- SBOX_SYNC, 1: 1 = synchronous (EBR) S-boxes, 2 cycles per round; 0 = combinational (LUT) S-boxes, 1 cycle per round.
- DONE_PULSE, 0: 0 = done is held high until the next accepted start; 1 = done is high for exactly one cycle.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request an encryption; sampled only in IDLE.
- key  in  128  cipher key, captured on start acceptance.
- plaintext  in  128  input block, captured on start acceptance.
- busy  out  1  high while encryption is in progress.
- done  out  1  ciphertext is valid.
- cyphertext  out  128  result; registered.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, cyphertext=0; round counter 0; state and key registers 0.
- Byte packing is as in aes_spi: [127:120] is S0,0; words w0..w3 are [127:96]..[31:0].
- Start acceptance: on the clk edge where state=IDLE and start=1:
  - state_reg <= plaintext ^ key; key_reg <= key; rnd <= 1;
  - busy goes high; done is cleared.
- start while busy: ignored; the inputs may change freely.
- SBOX_SYNC=1, per round:
  - Phase SUB: 16 state S-boxes plus 4 S-boxes on RotWord(key_reg w3) are registered.
  - Phase MIX: next key = expand(key_reg, rcon[rnd]); state_reg <= MixColumns(ShiftRows(sub)) ^ next key; key_reg <= next key.
  - Round 10 omits MixColumns.
- SBOX_SYNC=0: SUB and MIX are merged into one cycle.
- rcon sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36. Index it by rnd from a package constant table, not by doubling.
- State machine:
  - IDLE -> SUB on start;
  - SUB -> MIX;
  - MIX -> SUB if rnd<10, else -> DONE;
  - rnd increments in MIX;
  - DONE -> IDLE;
  - with SBOX_SYNC=0 the SUB state is skipped.
- Completion: in the DONE cycle, cyphertext <= state_reg; busy drops and done rises on the same edge.
- Latency: from the start-accept edge to the edge where done is first high = 10*(1+SBOX_SYNC)+1 cycles (21 or 11).
- Back-to-back: start may be high in the first cycle after done rises (IDLE). That restart is accepted with no dead cycle.
- cyphertext holds its value until the next completion; it does not change on start acceptance.
- DONE_PULSE=1: done is cleared automatically on the following edge.
- Reset mid-operation: abort immediately to the reset values; no partial result is exposed.
- Widths: rnd is 4 bits, range 1..10, never wraps past 10.

Optional Feature:
- Macro: AES_CORE_CBC_EN.
- When defined:
  - extra inputs iv[127:0] and chain_clr;
  - a 128-bit chain register, reset to 0;
  - at start acceptance the core XORs the chain value into the plaintext: state_reg <= plaintext ^ chain ^ key;
  - chain_clr=1 at the accept edge selects iv instead of chain;
  - chain <= cyphertext on each completion.
- When undefined: no extra ports or registers; pure ECB.

Decomposition:
- Package aes_pkg:
  - state enum (IDLE, SUB, MIX, DONE);
  - NR=10;
  - RCON table as a localparam array indexed 1..10;
  - helper functions shift_rows and rot_word.
- Sub-module aes_key_step:
  - takes key_reg, rcon and the S-box'd RotWord word;
  - produces the next round key combinationally.
- The core instantiates the existing sbox/sbox_sync and mixcolumns modules, selected by SBOX_SYNC through a generate block.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> cyphertext 69c4e0d86a7b0430d8cdb78070b4c55a. Run with SBOX_SYNC=1 (done at +21 cycles) and SBOX_SYNC=0 (done at +11 cycles).
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32. Then restart immediately in the first IDLE cycle; the second result must be correct, with no lost cycles.
- Pulse start mid-run at cycle 5 with a different key/pt -> ignored; result equals the C.1 vector; busy stays 1 until completion.
- Drop reset_n at cycle 8 of a run -> busy, done and cyphertext go to 0 asynchronously. After release, a fresh C.1 run completes correctly.
- DONE_PULSE=1 -> done is high for exactly one cycle; cyphertext stays stable for 50 cycles afterwards.
- AES_CORE_CBC_EN, chain_clr=1, iv=0 -> the C.1 vector. Then a second block with chain_clr=0 and the same pt -> the reference-model result of AES(pt ^ 69c4…c55a).
